// File: rtl/sram_like_bus_arbiter.sv
// Two-port (fetch/mem) arbiter onto one SRAM-like slave, with an in-order owner FIFO for response routing.
// Latency: 0-cycle request/response pass-through; backpressure: slave addr_ok stall locks the grant, MAX_OUT caps issue.

module sram_like_bus_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_dat_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 pop_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= bump(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= bump(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);
endmodule

module sram_like_bus_arbiter #(
  parameter int MAX_OUT     = 2,
  parameter int DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok,
  output logic        err_spurious
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(DATA_STREAK + 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  lock_e         state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data port
  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;

  logic          sel_data, sel_req, can_issue, fire, pop, head_tag, fifo_empty;
  logic [CW-1:0] fifo_count;

  always_comb begin
    sel_data  = 1'b1;
    if (state_q == LOCKED) sel_data = owner_q;
    else sel_data = (data_req && !(inst_req && (streak_q >= SW'(DATA_STREAK)))) || !inst_req;
    sel_req   = sel_data ? data_req : inst_req;
    can_issue = (fifo_count < CW'(MAX_OUT));
    mem_req   = can_issue & sel_req & ~reset;
    fire      = mem_req & mem_addr_ok;
  end

  assign mem_wr       = sel_data ? data_wr    : inst_wr;
  assign mem_size     = sel_data ? data_size  : inst_size;
  assign mem_wstrb    = sel_data ? data_wstrb : inst_wstrb;
  assign mem_addr     = sel_data ? data_addr  : inst_addr;
  assign mem_wdata    = sel_data ? data_wdata : inst_wdata;
  assign inst_addr_ok = fire & ~sel_data;
  assign data_addr_ok = fire & sel_data;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    case (state_q)
      UNLOCKED: if (mem_req && !mem_addr_ok) begin
        state_d = LOCKED;
        owner_d = sel_data;
      end
      LOCKED: if (fire || !sel_req) state_d = UNLOCKED;
      default: state_d = UNLOCKED;
    endcase
    if (!inst_req || (fire && !sel_data)) streak_d = '0;
    else if (fire && sel_data && (streak_q < SW'(DATA_STREAK))) streak_d = streak_q + SW'(1);
    err_d = err_q | (mem_data_ok & fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      owner_q  <= 1'b0;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  sram_like_bus_fifo #(.W(1), .DEPTH(MAX_OUT)) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fire),
    .push_dat_i (sel_data),
    .pop_i      (pop),
    .pop_dat_o  (head_tag),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  // A response with nothing outstanding is dropped rather than routed.
  assign pop          = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = pop & ~head_tag;
  assign data_data_ok = pop & head_tag;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_spurious = err_q;
endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
// Directed cycle-table bench for sram_like_bus_arbiter with hand-written reset/spurious sequences.

module tb_sram_like_bus_arbiter;
  localparam logic [31:0] IA = 32'h0000_1000;
  localparam logic [31:0] DA = 32'h0000_0100;
  localparam logic [31:0] IWD = 32'h1111_1111;
  localparam logic [31:0] DWD = 32'h2222_2222;

  logic clk, reset;
  logic inst_req, inst_addr_ok, inst_data_ok;
  logic data_req, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_spurious;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  sram_like_bus_arbiter #(.MAX_OUT(2), .DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(1'b0), .inst_size(2'd2), .inst_wstrb(4'hf),
    .inst_addr(IA), .inst_wdata(IWD), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(1'b1), .data_size(2'd1), .data_wstrb(4'h3),
    .data_addr(DA), .data_wdata(DWD), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        e_mreq, e_dsel, e_iaok, e_daok, e_idok, e_ddok, e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t post[$];

  function automatic vec_t mv(input string n, input logic i, input logic d, input logic a,
                              input logic k, input logic [31:0] r, input logic mr, input logic ds,
                              input logic ia, input logic da, input logic io, input logic dd,
                              input logic e);
    vec_t v;
    v.name = n; v.ireq = i; v.dreq = d; v.aok = a; v.dok = k; v.rdata = r;
    v.e_mreq = mr; v.e_dsel = ds; v.e_iaok = ia; v.e_daok = da;
    v.e_idok = io; v.e_ddok = dd; v.e_err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic i, input logic d, input logic a, input logic k, input logic [31:0] r);
    inst_req = i; data_req = d; mem_addr_ok = a; mem_data_ok = k; mem_rdata = r;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v.ireq, v.dreq, v.aok, v.dok, v.rdata);
    #2;
    chk({v.name, ".mem_req"},      mem_req,      v.e_mreq);
    chk({v.name, ".mem_addr"},     mem_addr,     v.e_dsel ? DA : IA);
    chk({v.name, ".mem_wdata"},    mem_wdata,    v.e_dsel ? DWD : IWD);
    chk({v.name, ".mem_ctl"},      {mem_wr, mem_size, mem_wstrb},
        v.e_dsel ? {1'b1, 2'd1, 4'h3} : {1'b0, 2'd2, 4'hf});
    chk({v.name, ".inst_addr_ok"}, inst_addr_ok, v.e_iaok);
    chk({v.name, ".data_addr_ok"}, data_addr_ok, v.e_daok);
    chk({v.name, ".inst_data_ok"}, inst_data_ok, v.e_idok);
    chk({v.name, ".data_data_ok"}, data_data_ok, v.e_ddok);
    chk({v.name, ".rdata"},        {inst_rdata ^ v.rdata} | {data_rdata ^ v.rdata}, 32'h0);
    chk({v.name, ".err"},          err_spurious, v.e_err);
  endtask

  task automatic chk_quiet(input string nm, input logic e);
    chk({nm, ".mem_req"},      mem_req,      1'b0);
    chk({nm, ".inst_addr_ok"}, inst_addr_ok, 1'b0);
    chk({nm, ".data_addr_ok"}, data_addr_ok, 1'b0);
    chk({nm, ".inst_data_ok"}, inst_data_ok, 1'b0);
    chk({nm, ".data_data_ok"}, data_data_ok, 1'b0);
    chk({nm, ".err"},          err_spurious, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            name       I D A K rdata          mr ds ia da io dd err
    tbl.push_back(mv("t1c0", 0,1,1,0,32'h0,         1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mv("t1c1", 0,0,0,0,32'h0,         0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mv("t1c2", 0,0,0,1,32'hDEADBEEF,  0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mv("t2c0", 1,1,1,0,32'h0,         1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mv("t2c1", 1,0,1,0,32'h0,         1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mv("t2c2", 0,0,0,1,32'hA,         0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mv("t2c3", 0,0,0,1,32'hB,         0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mv("t3c0", 1,0,0,0,32'h0,         1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv("t3c1", 1,1,0,0,32'h0,         1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv("t3c2", 1,1,0,0,32'h0,         1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv("t3c3", 1,1,1,0,32'h0,         1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mv("t3c4", 0,1,1,0,32'h0,         1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mv("t3c5", 0,0,0,1,32'h33,        0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mv("t3c6", 0,0,0,1,32'h44,        0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mv("t4c0", 1,1,1,0,32'h0,         1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mv("t4c1", 1,1,1,1,32'h50,        1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mv("t4c2", 1,1,1,1,32'h51,        1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mv("t4c3", 1,1,1,1,32'h52,        1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mv("t4c4", 1,1,1,1,32'h53,        1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mv("t4c5", 1,1,1,1,32'h54,        1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mv("t4c6", 0,0,0,1,32'h55,        0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mv("t5c0", 0,1,1,0,32'h0,         1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mv("t5c1", 1,0,1,0,32'h0,         1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mv("t5c2", 1,1,1,0,32'h0,         0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mv("t5c3", 1,1,1,1,32'h61,        0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mv("t5c4", 1,1,1,1,32'h62,        1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mv("t5c5", 1,0,1,0,32'h0,         1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mv("t5c6", 1,1,1,0,32'h0,         0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mv("t5c7", 0,0,0,1,32'h63,        0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mv("t5c8", 0,0,0,1,32'h64,        0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mv("t6c0", 0,1,1,0,32'h0,         1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mv("t6c1", 1,0,1,0,32'h0,         1, 0, 1, 0, 0, 0, 0));

    post.push_back(mv("p0",  0,0,0,1,32'h71,        0, 1, 0, 0, 0, 0, 0));
    post.push_back(mv("p1",  0,0,0,0,32'h0,         0, 1, 0, 0, 0, 0, 1));
    post.push_back(mv("p2",  0,1,1,0,32'h0,         1, 1, 0, 1, 0, 0, 1));
    post.push_back(mv("p3",  1,0,1,0,32'h0,         1, 0, 1, 0, 0, 0, 1));
    post.push_back(mv("p4",  0,1,1,0,32'h0,         0, 1, 0, 0, 0, 0, 1));
    post.push_back(mv("p5",  0,0,0,1,32'h72,        0, 1, 0, 0, 0, 1, 1));
    post.push_back(mv("p6",  0,0,0,1,32'h73,        0, 1, 0, 0, 1, 0, 1));

    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    #1;
    chk_quiet("reset0", 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset with two transactions outstanding and every input active.
    @(negedge clk);
    drive(1, 1, 1, 1, 32'h70);
    #1 reset = 1'b1;
    #1 chk_quiet("midreset", 1'b0);
    drive(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (post[i]) apply(post[i]);

    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    #2 chk_quiet("err_clear", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
